// File: rtl/row_window_ctrl.sv
// rtl/row_window_ctrl.sv - three-slot row-buffer fill and window sweep sequencer
// Loads grid rows into three rotating slots and sweeps upper/middle/lower windows out.
module row_window_ctrl #(
   parameter int  ROW_SIZE     = 64,
   parameter int  MODULAR_SIZE = 32,
   parameter int  NUM_ROWS     = 64,
   localparam int NW           = (ROW_SIZE + MODULAR_SIZE - 1) / MODULAR_SIZE,
   localparam int WIB          = (NW > 1) ? $clog2(NW) : 1,
   localparam int RB           = ($clog2(NUM_ROWS + 1) > 1) ? $clog2(NUM_ROWS + 1) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    in_valid,
   input  logic [MODULAR_SIZE-1:0] in_data,
   output logic                    in_ready,
   output logic                    wr_en,
   output logic [1:0]              wr_slot,
   output logic [MODULAR_SIZE-1:0] wr_data,
   output logic [WIB-1:0]          word_index,
   output logic                    win_valid,
   input  logic                    win_ready,
   output logic [1:0]              slot_u,
   output logic [1:0]              slot_m,
   output logic [1:0]              slot_l,
   output logic                    upper_zero,
   output logic                    lower_zero,
   output logic                    win_last_word,
   output logic [RB-1:0]           mid_row,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_SWEEP = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [WIB-1:0] LAST_WORD = WIB'(NW - 1);
   localparam logic [RB-1:0]  LAST_ROW  = RB'(NUM_ROWS - 1);

   // Slot numbers are tracked incrementally mod 3 so no divider is needed.
   function automatic logic [1:0] slot_inc(input logic [1:0] s);
      return (s == 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   state_t         state_q, state_d;
   logic [WIB-1:0] wcnt_q, wcnt_d;
   logic [WIB-1:0] rcnt_q, rcnt_d;
   logic [RB-1:0]  rows_q, rows_d;
   logic [RB-1:0]  mid_q, mid_d;
   logic [1:0]     wslot_q, wslot_d;
   logic [1:0]     mslot_q, mslot_d;
   logic [RB-1:0]  rows_inc;

   assign rows_inc = rows_q + 1'b1;
   assign mid_row  = mid_q;
   assign busy     = (state_q != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         rcnt_q  <= '0;
         rows_q  <= '0;
         mid_q   <= '0;
         wslot_q <= '0;
         mslot_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         rcnt_q  <= rcnt_d;
         rows_q  <= rows_d;
         mid_q   <= mid_d;
         wslot_q <= wslot_d;
         mslot_q <= mslot_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      wcnt_d        = wcnt_q;
      rcnt_d        = rcnt_q;
      rows_d        = rows_q;
      mid_d         = mid_q;
      wslot_d       = wslot_q;
      mslot_d       = mslot_q;
      in_ready      = 1'b0;
      wr_en         = 1'b0;
      wr_slot       = 2'd0;
      wr_data       = '0;
      word_index    = '0;
      win_valid     = 1'b0;
      slot_u        = 2'd0;
      slot_m        = 2'd0;
      slot_l        = 2'd0;
      upper_zero    = 1'b0;
      lower_zero    = 1'b0;
      win_last_word = 1'b0;
      done          = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FILL;
               wcnt_d  = '0;
               rcnt_d  = '0;
               rows_d  = '0;
               mid_d   = '0;
               wslot_d = 2'd0;
               mslot_d = 2'd0;
            end
         end

         S_FILL: begin
            in_ready   = 1'b1;
            word_index = wcnt_q;
            if (in_valid) begin
               wr_en   = 1'b1;
               wr_slot = wslot_q;
               wr_data = in_data;
               if (wcnt_q == LAST_WORD) begin
                  wcnt_d  = '0;
                  rows_d  = rows_inc;
                  wslot_d = slot_inc(wslot_q);
                  // The first sweep needs rows 0 and 1; afterwards one new row per sweep.
                  if ((int'(rows_inc) >= 2) || (NUM_ROWS == 1)) begin
                     state_d = S_SWEEP;
                  end
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end

         S_SWEEP: begin
            win_valid     = 1'b1;
            word_index    = rcnt_q;
            slot_m        = mslot_q;
            slot_l        = slot_inc(mslot_q);
            slot_u        = slot_inc(slot_inc(mslot_q));
            upper_zero    = (mid_q == '0);
            lower_zero    = (mid_q == LAST_ROW);
            win_last_word = (rcnt_q == LAST_WORD);
            if (win_ready) begin
               if (rcnt_q == LAST_WORD) begin
                  rcnt_d  = '0;
                  mid_d   = mid_q + 1'b1;
                  mslot_d = slot_inc(mslot_q);
                  if (mid_q == LAST_ROW) begin
                     state_d = S_DONE;
                  end else if (int'(rows_q) < NUM_ROWS) begin
                     state_d = S_FILL;
                  end
               end else begin
                  rcnt_d = rcnt_q + 1'b1;
               end
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_row_window_ctrl.sv
// tb/tb_row_window_ctrl.sv - self-checking bench for row_window_ctrl
// Three instances (NUM_ROWS 3, 1, 5) with NW=2; cycle table plus event scoreboard jobs.
module tb_row_window_ctrl;

   localparam int NW = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        start_s[3], in_valid_s[3], win_ready_s[3];
   logic [31:0] in_data_s[3], wr_data_s[3];
   logic        in_ready_s[3], wr_en_s[3], win_valid_s[3];
   logic        uz_s[3], lz_s[3], last_s[3], busy_s[3], done_s[3];
   logic [1:0]  wr_slot_s[3], su_s[3], sm_s[3], sl_s[3];
   logic        wi_s[3];
   logic [2:0]  mid_s[3];

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int NR  = (g == 0) ? 3 : ((g == 1) ? 1 : 5);
      localparam int RBG = ($clog2(NR + 1) > 1) ? $clog2(NR + 1) : 1;
      logic [RBG-1:0] mr;
      row_window_ctrl #(.ROW_SIZE(64), .MODULAR_SIZE(32), .NUM_ROWS(NR)) u_dut (
         .clk(clk), .reset(reset), .start(start_s[g]),
         .in_valid(in_valid_s[g]), .in_data(in_data_s[g]), .in_ready(in_ready_s[g]),
         .wr_en(wr_en_s[g]), .wr_slot(wr_slot_s[g]), .wr_data(wr_data_s[g]),
         .word_index(wi_s[g]), .win_valid(win_valid_s[g]), .win_ready(win_ready_s[g]),
         .slot_u(su_s[g]), .slot_m(sm_s[g]), .slot_l(sl_s[g]),
         .upper_zero(uz_s[g]), .lower_zero(lz_s[g]), .win_last_word(last_s[g]),
         .mid_row(mr), .busy(busy_s[g]), .done(done_s[g])
      );
      assign mid_s[g] = 3'(mr);
   end

   typedef struct packed {
      logic       in_ready;
      logic       wr_en;
      logic [1:0] wr_slot;
      logic       wi;
      logic       win_valid;
      logic [1:0] u;
      logic [1:0] m;
      logic [1:0] l;
      logic       uz;
      logic       lz;
      logic       last;
      logic [2:0] mid;
      logic       busy;
      logic       done;
   } outs_t;

   typedef struct {
      logic  st;
      logic  iv;
      logic  wr;
      outs_t exp;
   } vec_t;

   function automatic outs_t sample(input int d);
      outs_t o;
      o.in_ready = in_ready_s[d];  o.wr_en = wr_en_s[d];  o.wr_slot = wr_slot_s[d];
      o.wi = wi_s[d];  o.win_valid = win_valid_s[d];
      o.u = su_s[d];  o.m = sm_s[d];  o.l = sl_s[d];
      o.uz = uz_s[d];  o.lz = lz_s[d];  o.last = last_s[d];
      o.mid = mid_s[d];  o.busy = busy_s[d];  o.done = done_s[d];
      return o;
   endfunction

   function automatic outs_t mk(input int ir, we, ws, wi, wv, u, m, l, uz, lz, ls, mr, bz, dn);
      outs_t o;
      o.in_ready = ir[0];  o.wr_en = we[0];  o.wr_slot = 2'(ws);  o.wi = wi[0];
      o.win_valid = wv[0];  o.u = 2'(u);  o.m = 2'(m);  o.l = 2'(l);
      o.uz = uz[0];  o.lz = lz[0];  o.last = ls[0];  o.mid = 3'(mr);
      o.busy = bz[0];  o.done = dn[0];
      return o;
   endfunction

   function automatic vec_t mv(input int st, iv, wr, outs_t e);
      vec_t v;
      v.st = st[0];  v.iv = iv[0];  v.wr = wr[0];  v.exp = e;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int wr_ev(input int slot, input int w);
      return (slot << 4) | w;
   endfunction

   function automatic int beat_ev(input int nr, input int m, input int w);
      return (1 << 20) | (m << 12) | (((m + 2) % 3) << 10) | ((m % 3) << 8) | (((m + 1) % 3) << 6)
             | (((m == 0) ? 1 : 0) << 5) | (((m == nr - 1) ? 1 : 0) << 4)
             | (((w == NW - 1) ? 1 : 0) << 3) | w;
   endfunction

   // Scoreboard monitor for the instance selected by mon_d
   bit  mon_en = 1'b0;
   int  mon_d = 0;
   int  expq[$];
   int  beats = 0;
   int  dones = 0;
   bit  prev_stall = 1'b0;
   int  prev_win = 0;

   function automatic int win_snap(input int d);
      return (int'(su_s[d]) << 12) | (int'(sm_s[d]) << 10) | (int'(sl_s[d]) << 8)
             | (int'(uz_s[d]) << 7) | (int'(lz_s[d]) << 6) | (int'(last_s[d]) << 5)
             | (int'(wi_s[d]) << 4) | (int'(mid_s[d]) << 1) | int'(win_valid_s[d]);
   endfunction

   task automatic take_event(input int ev);
      if (expq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event actual=%0h required=none", ev);
      end else begin
         chk("event_order", ev, expq.pop_front());
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_stall && !reset) chk("stall_hold", win_snap(mon_d), prev_win);
         if (wr_en_s[mon_d]) begin
            chk("wr_needs_valid", int'(in_valid_s[mon_d]), 1);
            chk("wr_data", int'(wr_data_s[mon_d]), int'(in_data_s[mon_d]));
            take_event(wr_ev(int'(wr_slot_s[mon_d]), int'(wi_s[mon_d])));
         end
         if (win_valid_s[mon_d] && win_ready_s[mon_d]) begin
            beats++;
            take_event((1 << 20) | (int'(mid_s[mon_d]) << 12) | (int'(su_s[mon_d]) << 10)
                       | (int'(sm_s[mon_d]) << 8) | (int'(sl_s[mon_d]) << 6)
                       | (int'(uz_s[mon_d]) << 5) | (int'(lz_s[mon_d]) << 4)
                       | (int'(last_s[mon_d]) << 3) | int'(wi_s[mon_d]));
         end
         if (done_s[mon_d]) dones++;
         prev_stall = win_valid_s[mon_d] && !win_ready_s[mon_d];
         prev_win   = win_snap(mon_d);
      end else begin
         prev_stall = 1'b0;
      end
   end

   function automatic int nr_of(input int d);
      return (d == 0) ? 3 : ((d == 1) ? 1 : 5);
   endfunction

   task automatic build_exp(input int nr);
      expq.delete();
      for (int r = 0; r < ((nr < 2) ? nr : 2); r++)
         for (int w = 0; w < NW; w++) expq.push_back(wr_ev(r % 3, w));
      for (int m = 0; m < nr; m++) begin
         for (int w = 0; w < NW; w++) expq.push_back(beat_ev(nr, m, w));
         if (m + 2 < nr)
            for (int w = 0; w < NW; w++) expq.push_back(wr_ev((m + 2) % 3, w));
      end
   endtask

   task automatic idle_inputs();
      for (int d = 0; d < 3; d++) begin
         start_s[d] = 1'b0;  in_valid_s[d] = 1'b0;  win_ready_s[d] = 1'b0;  in_data_s[d] = '0;
      end
   endtask

   task automatic run_job(input int d, input bit gaps, input bit spam);
      int nr;
      nr = nr_of(d);
      mon_d = d;
      build_exp(nr);
      beats = 0;
      dones = 0;
      mon_en = 1'b1;
      start_s[d] = 1'b1;  in_valid_s[d] = 1'b1;  win_ready_s[d] = 1'b1;  in_data_s[d] = $urandom;
      @(posedge clk); #1;
      start_s[d] = 1'b0;
      for (int cyc = 0; cyc < 3000 && dones == 0; cyc++) begin
         in_valid_s[d]  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         win_ready_s[d] = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         in_data_s[d]   = $urandom;
         start_s[d]     = spam && busy_s[d] && !done_s[d] && ($urandom_range(0, 3) == 0);
         @(posedge clk); #1;
      end
      start_s[d] = 1'b0;  in_valid_s[d] = 1'b1;  win_ready_s[d] = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      mon_en = 1'b0;
      chk($sformatf("events_left_d%0d", d), expq.size(), 0);
      chk($sformatf("beats_d%0d", d), beats, nr * NW);
      chk($sformatf("done_pulses_d%0d", d), dones, 1);
      chk($sformatf("idle_after_d%0d", d), int'(busy_s[d]), 0);
      idle_inputs();
   endtask

   vec_t tbl[$];

   initial begin
      tbl.push_back(mv(1,1,1, mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0)));
      tbl.push_back(mv(0,1,1, mk(1,1,0,0,0, 0,0,0, 0,0,0, 0,1,0)));
      tbl.push_back(mv(0,1,1, mk(1,1,0,1,0, 0,0,0, 0,0,0, 0,1,0)));
      tbl.push_back(mv(0,0,1, mk(1,0,0,0,0, 0,0,0, 0,0,0, 0,1,0)));
      tbl.push_back(mv(0,1,1, mk(1,1,1,0,0, 0,0,0, 0,0,0, 0,1,0)));
      tbl.push_back(mv(0,1,1, mk(1,1,1,1,0, 0,0,0, 0,0,0, 0,1,0)));
      tbl.push_back(mv(0,1,0, mk(0,0,0,0,1, 2,0,1, 1,0,0, 0,1,0)));
      tbl.push_back(mv(0,1,1, mk(0,0,0,0,1, 2,0,1, 1,0,0, 0,1,0)));
      tbl.push_back(mv(0,1,1, mk(0,0,0,1,1, 2,0,1, 1,0,1, 0,1,0)));
      tbl.push_back(mv(0,1,1, mk(1,1,2,0,0, 0,0,0, 0,0,0, 1,1,0)));
      tbl.push_back(mv(0,1,1, mk(1,1,2,1,0, 0,0,0, 0,0,0, 1,1,0)));
      tbl.push_back(mv(0,1,1, mk(0,0,0,0,1, 0,1,2, 0,0,0, 1,1,0)));
      tbl.push_back(mv(0,1,1, mk(0,0,0,1,1, 0,1,2, 0,0,1, 1,1,0)));
      tbl.push_back(mv(0,1,1, mk(0,0,0,0,1, 1,2,0, 0,1,0, 2,1,0)));
      tbl.push_back(mv(0,1,1, mk(0,0,0,1,1, 1,2,0, 0,1,1, 2,1,0)));
      tbl.push_back(mv(1,1,1, mk(0,0,0,0,0, 0,0,0, 0,0,0, 3,1,1)));
      tbl.push_back(mv(0,1,1, mk(0,0,0,0,0, 0,0,0, 0,0,0, 3,0,0)));

      idle_inputs();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset_outs_d%0d", d), int'(sample(d)), 0);
         chk($sformatf("reset_wr_data_d%0d", d), int'(wr_data_s[d]), 0);
      end
      @(posedge clk); #1;

      for (int i = 0; i < tbl.size(); i++) begin
         start_s[0] = tbl[i].st;  in_valid_s[0] = tbl[i].iv;  win_ready_s[0] = tbl[i].wr;
         in_data_s[0] = $urandom;
         @(negedge clk);
         chk($sformatf("vec%0d", i), int'(sample(0)), int'(tbl[i].exp));
         @(posedge clk); #1;
      end
      idle_inputs();

      run_job(0, 1'b0, 1'b0);
      run_job(0, 1'b1, 1'b0);
      run_job(1, 1'b0, 1'b0);
      run_job(2, 1'b1, 1'b0);
      run_job(2, 1'b0, 1'b1);

      // Reset during the second window beat of a job
      mon_d = 0;
      build_exp(3);
      beats = 0;
      dones = 0;
      mon_en = 1'b1;
      start_s[0] = 1'b1;  in_valid_s[0] = 1'b1;  win_ready_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      for (int cyc = 0; cyc < 100 && beats == 0; cyc++) begin
         in_data_s[0] = $urandom;
         @(posedge clk); #1;
      end
      chk("first_beat_seen", beats, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      mon_en = 1'b0;
      chk("reset_hit_second_beat", beats, 2);
      @(negedge clk);
      chk("reset_mid_sweep_outs", int'(sample(0)), 0);
      @(posedge clk); #1;
      idle_inputs();
      run_job(0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
